rgb_fade_ctrl: RTL and testbench

Command-driven fade sequencer for the three-channel RGB LED path on the UP5K. Accepts target colour commands over a valid/ready handshake, ramps each channel's duty one LSB at a time toward its target at a programmable rate, and generates glitch-free PWM for the `SB_RGBA_DRV` RGB0PWM/RGB1PWM/RGB2PWM inputs. It sits between any command source (CPU register, pattern ROM) and the hard LED driver.

---
 rtl/rgb_fade_pkg.sv | 20 ++
 rtl/rgb_pwm_gen.sv | 61 ++++++
 rtl/rgb_fade_ctrl.sv | 132 +++++++++++++
 tb/tb_rgb_fade_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fade_pkg.sv
// Shared types, default widths and the gamma helper for the RGB fade sequencer.
// RGB_FADE_GAMMA_EN selects the gamma-2.0 duty mapping in rgb_pwm_gen.
package rgb_fade_pkg;

  localparam int PWM_WIDTH_DEF  = 12;
  localparam int RATE_WIDTH_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FADE = 1'b1
  } fade_state_t;

  // (duty*duty) >> width; the full product is kept so nothing is lost before the shift.
  function automatic logic [31:0] gamma_map(input logic [31:0] duty, input int unsigned width);
    logic [63:0] prod;
    prod = {32'd0, duty} * {32'd0, duty};
    return 32'(prod >> width);
  endfunction

endpackage

// File: rtl/rgb_pwm_gen.sv
// Free-running PWM counter, per-channel shadow duties and registered compare outputs.
// With RGB_FADE_GAMMA_EN defined the shadows load a gamma-2.0 mapped duty.
module rgb_pwm_gen
  import rgb_fade_pkg::*;
#(
  parameter int PWM_WIDTH = PWM_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [PWM_WIDTH-1:0] i_duty_r,
  input  logic [PWM_WIDTH-1:0] i_duty_g,
  input  logic [PWM_WIDTH-1:0] i_duty_b,
  output logic                 o_pwm_r,
  output logic                 o_pwm_g,
  output logic                 o_pwm_b
);

  localparam logic [PWM_WIDTH-1:0] CTR_MAX = {PWM_WIDTH{1'b1}};
  localparam logic [PWM_WIDTH-1:0] CTR_ONE = PWM_WIDTH'(1);

  logic [PWM_WIDTH-1:0] r_ctr;
  logic [PWM_WIDTH-1:0] r_shadow_r, r_shadow_g, r_shadow_b;
  logic [PWM_WIDTH-1:0] w_map_r, w_map_g, w_map_b;
  logic                 w_wrap;

  assign w_wrap = (r_ctr == CTR_MAX);

`ifdef RGB_FADE_GAMMA_EN
  assign w_map_r = PWM_WIDTH'(gamma_map(32'(i_duty_r), PWM_WIDTH));
  assign w_map_g = PWM_WIDTH'(gamma_map(32'(i_duty_g), PWM_WIDTH));
  assign w_map_b = PWM_WIDTH'(gamma_map(32'(i_duty_b), PWM_WIDTH));
`else
  assign w_map_r = i_duty_r;
  assign w_map_g = i_duty_g;
  assign w_map_b = i_duty_b;
`endif

  // Shadows only change at the period boundary so a period never sees two duties.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ctr      <= {PWM_WIDTH{1'b0}};
      r_shadow_r <= {PWM_WIDTH{1'b0}};
      r_shadow_g <= {PWM_WIDTH{1'b0}};
      r_shadow_b <= {PWM_WIDTH{1'b0}};
      o_pwm_r    <= 1'b0;
      o_pwm_g    <= 1'b0;
      o_pwm_b    <= 1'b0;
    end else begin
      r_ctr   <= r_ctr + CTR_ONE;
      o_pwm_r <= (r_ctr < r_shadow_r);
      o_pwm_g <= (r_ctr < r_shadow_g);
      o_pwm_b <= (r_ctr < r_shadow_b);
      if (w_wrap) begin
        r_shadow_r <= w_map_r;
        r_shadow_g <= w_map_g;
        r_shadow_b <= w_map_b;
      end
    end
  end

endmodule

// File: rtl/rgb_fade_ctrl.sv
// Command-driven RGB fade sequencer: IDLE/FADE FSM, step prescaler and per-channel ramp.
// Optional RGB_FADE_GAMMA_EN enables gamma mapping inside rgb_pwm_gen.
module rgb_fade_ctrl
  import rgb_fade_pkg::*;
#(
  parameter int PWM_WIDTH  = PWM_WIDTH_DEF,
  parameter int RATE_WIDTH = RATE_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [PWM_WIDTH-1:0]  cmd_r,
  input  logic [PWM_WIDTH-1:0]  cmd_g,
  input  logic [PWM_WIDTH-1:0]  cmd_b,
  input  logic [RATE_WIDTH-1:0] cmd_rate,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  pwm_r,
  output logic                  pwm_g,
  output logic                  pwm_b
);

  localparam logic [PWM_WIDTH-1:0]  DUTY_ONE = PWM_WIDTH'(1);
  localparam logic [RATE_WIDTH-1:0] RATE_ONE = RATE_WIDTH'(1);

  fade_state_t           r_state, w_state_nxt;
  logic [PWM_WIDTH-1:0]  r_cur_r, r_cur_g, r_cur_b;
  logic [PWM_WIDTH-1:0]  r_tgt_r, r_tgt_g, r_tgt_b;
  logic [RATE_WIDTH-1:0] r_rate, r_presc;
  logic                  r_done;
  logic                  w_accept, w_step, w_dec, w_done_nxt, w_all_eq;

  function automatic logic [PWM_WIDTH-1:0] step_toward(input logic [PWM_WIDTH-1:0] cur,
                                                       input logic [PWM_WIDTH-1:0] tgt);
    if (cur < tgt)      return cur + DUTY_ONE;
    else if (cur > tgt) return cur - DUTY_ONE;
    else                return cur;
  endfunction

  assign w_all_eq  = (r_cur_r == r_tgt_r) && (r_cur_g == r_tgt_g) && (r_cur_b == r_tgt_b);
  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state == ST_FADE);
  assign done      = r_done;

  // FSM state register and the registered completion pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state decode; abort outranks completion, completion outranks stepping.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_dec       = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = ST_FADE;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FADE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_all_eq) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_presc == {RATE_WIDTH{1'b0}}) begin
          w_step = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Command latch, prescaler and duty ramp.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cur_r <= {PWM_WIDTH{1'b0}};
      r_cur_g <= {PWM_WIDTH{1'b0}};
      r_cur_b <= {PWM_WIDTH{1'b0}};
      r_tgt_r <= {PWM_WIDTH{1'b0}};
      r_tgt_g <= {PWM_WIDTH{1'b0}};
      r_tgt_b <= {PWM_WIDTH{1'b0}};
      r_rate  <= {RATE_WIDTH{1'b0}};
      r_presc <= {RATE_WIDTH{1'b0}};
    end else if (w_accept) begin
      r_tgt_r <= cmd_r;
      r_tgt_g <= cmd_g;
      r_tgt_b <= cmd_b;
      r_rate  <= cmd_rate;
      r_presc <= cmd_rate;
    end else if (w_step) begin
      r_cur_r <= step_toward(r_cur_r, r_tgt_r);
      r_cur_g <= step_toward(r_cur_g, r_tgt_g);
      r_cur_b <= step_toward(r_cur_b, r_tgt_b);
      r_presc <= r_rate;
    end else if (w_dec) begin
      r_presc <= r_presc - RATE_ONE;
    end
  end

  rgb_pwm_gen #(
    .PWM_WIDTH(PWM_WIDTH)
  ) u_pwm (
    .clk      (clk),
    .resetn   (resetn),
    .i_duty_r (r_cur_r),
    .i_duty_g (r_cur_g),
    .i_duty_b (r_cur_b),
    .o_pwm_r  (pwm_r),
    .o_pwm_g  (pwm_g),
    .o_pwm_b  (pwm_b)
  );

endmodule

// File: tb/tb_rgb_fade_ctrl.sv
// Directed bench for rgb_fade_ctrl; done pulses are checked against a queue of expected cycles.
module tb_rgb_fade_ctrl;

  logic        clk;
  logic        resetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] cmd_r, cmd_g, cmd_b;
  logic [15:0] cmd_rate;
  logic        abort;
  logic        busy, done;
  logic        pwm_r, pwm_g, pwm_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int sb[$];
  int exp_c;

  rgb_fade_ctrl dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_r     (cmd_r),
    .cmd_g     (cmd_g),
    .cmd_b     (cmd_b),
    .cmd_rate  (cmd_rate),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .pwm_r     (pwm_r),
    .pwm_g     (pwm_g),
    .pwm_b     (pwm_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exp_high(input int d);
`ifdef RGB_FADE_GAMMA_EN
    return (d * d) >> 12;
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic send(input int r, input int g, input int b, input int rate, output int e0);
    chk("ready_before_cmd", int'(cmd_ready), 1);
    cmd_r     = 12'(r);
    cmd_g     = 12'(g);
    cmd_b     = 12'(b);
    cmd_rate  = 16'(rate);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n;
    n = 0;
    while (cmd_ready !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    chk(tag, int'(cmd_ready), 1);
  endtask

  // Scoreboard: every done pulse must match the oldest expected completion cycle.
  always @(posedge clk) begin
    #1;
    if (resetn === 1'b1 && done === 1'b1) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL done_spurious observed=cycle%0d expected=no_pulse", cyc);
      end
      if (sb.size() != 0) begin
        exp_c = sb.pop_front();
        checks++;
        assert (cyc === exp_c) else begin
          failures++;
          $error("FAIL done_cycle observed=%0d expected=%0d", cyc, exp_c);
        end
      end
    end
  end

  initial begin
    int e0, e1, n, cnt_r, cnt_g;
    logic prev;
    resetn    = 1'b0;
    cmd_valid = 1'b0;
    cmd_r     = 12'd0;
    cmd_g     = 12'd0;
    cmd_b     = 12'd0;
    cmd_rate  = 16'd0;
    abort     = 1'b0;
    #12;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pwm_r", int'(pwm_r), 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    // Ramp r 0 -> 10 at rate 0: one step per cycle.
    send(10, 0, 0, 0, e0);
    sb.push_back(e0 + 11);
    chk("a_busy", int'(busy), 1);
    chk("a_ready_low", int'(cmd_ready), 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("a_step_r", int'(dut.r_cur_r), k);
    end
    chk("a_busy_at_last_step", int'(busy), 1);
    tick();
    chk("a_ready_back", int'(cmd_ready), 1);
    chk("a_busy_clear", int'(busy), 0);
    tick();

    // Descend to r=8, then mixed-direction fade to r=6 g=3 at rate 3.
    send(8, 0, 0, 0, e0);
    sb.push_back(e0 + 3);
    wait_idle(10, "b_pre_idle");
    tick();
    send(6, 3, 0, 3, e0);
    sb.push_back(e0 + 13);
    repeat (3) tick();
    chk("b_e3_r", int'(dut.r_cur_r), 8);
    chk("b_e3_g", int'(dut.r_cur_g), 0);
    tick();
    chk("b_e4_r", int'(dut.r_cur_r), 7);
    chk("b_e4_g", int'(dut.r_cur_g), 1);
    repeat (4) tick();
    chk("b_e8_r", int'(dut.r_cur_r), 6);
    chk("b_e8_g", int'(dut.r_cur_g), 2);
    repeat (4) tick();
    chk("b_e12_r", int'(dut.r_cur_r), 6);
    chk("b_e12_g", int'(dut.r_cur_g), 3);
    chk("b_e12_busy", int'(busy), 1);
    tick();
    chk("b_e13_ready", int'(cmd_ready), 1);
    tick();

    // Abort on the 5th FADE cycle of 0 -> 100 with a second command held waiting.
    send(0, 0, 0, 0, e0);
    sb.push_back(e0 + 7);
    wait_idle(20, "c_pre_idle");
    tick();
    send(100, 100, 100, 0, e0);
    cmd_r     = 12'd2;
    cmd_g     = 12'd0;
    cmd_b     = 12'd0;
    cmd_rate  = 16'd0;
    cmd_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("c_backpressure", int'(cmd_ready), 0);
    end
    chk("c_e4_r", int'(dut.r_cur_r), 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("c_abort_busy", int'(busy), 0);
    chk("c_abort_ready", int'(cmd_ready), 1);
    chk("c_frozen_r", int'(dut.r_cur_r), 4);
    chk("c_frozen_g", int'(dut.r_cur_g), 4);
    chk("c_frozen_b", int'(dut.r_cur_b), 4);
    tick();
    cmd_valid = 1'b0;
    e1 = cyc;
    sb.push_back(e1 + 5);
    chk("c_held_accepted", int'(busy), 1);
    wait_idle(20, "c_second_idle");
    chk("c_second_r", int'(dut.r_cur_r), 2);
    chk("c_second_g", int'(dut.r_cur_g), 0);
    tick();

    // PWM: settle at duty 1024, then change mid-period to 2000.
    send(1024, 0, 0, 0, e0);
    sb.push_back(e0 + 1023);
    wait_idle(1100, "d_fade_idle");
    repeat (4097) tick();
    n = 0;
    prev = pwm_r;
    tick();
    while (!(prev === 1'b0 && pwm_r === 1'b1) && n < 5000) begin
      prev = pwm_r;
      tick();
      n++;
    end
    chk("d_found_period_start", int'(n < 5000), 1);
    cnt_r = 0;
    cnt_g = 0;
    for (int i = 0; i < 4096; i++) begin
      cnt_r += int'(pwm_r);
      cnt_g += int'(pwm_g);
      if (i == 100) begin
        cmd_r     = 12'd2000;
        cmd_g     = 12'd0;
        cmd_b     = 12'd0;
        cmd_rate  = 16'd0;
        cmd_valid = 1'b1;
      end
      if (i == 101) begin
        cmd_valid = 1'b0;
        e0 = cyc;
        sb.push_back(e0 + 977);
      end
      tick();
    end
    chk("d_high_1024", cnt_r, exp_high(1024));
    chk("d_duty0_low", cnt_g, 0);
    cnt_r = 0;
    for (int i = 0; i < 4096; i++) begin
      cnt_r += int'(pwm_r);
      tick();
    end
    chk("d_high_2000", cnt_r, exp_high(2000));

    // Asynchronous reset in the middle of a slow fade while pwm_r is high.
    send(0, 0, 0, 5, e0);
    tick();
    chk("e_busy", int'(busy), 1);
    n = 0;
    while (pwm_r !== 1'b1 && n < 4096) begin
      tick();
      n++;
    end
    chk("e_pwm_high_before_rst", int'(pwm_r), 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("e_rst_pwm_r", int'(pwm_r), 0);
    chk("e_rst_busy", int'(busy), 0);
    chk("e_rst_done", int'(done), 0);
    chk("e_rst_ready", int'(cmd_ready), 1);
    chk("e_rst_cur_r", int'(dut.r_cur_r), 0);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    chk("e_post_ready", int'(cmd_ready), 1);
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
